// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter and sequencer that lets N_REQ byte producers share one
// uart_tx serializer.  One requester is granted at a time.  The granted byte is
// held on tx_wdata for the whole frame because uart_tx reads wdata bit by bit
// and does not latch it.  A single-cycle tx_wrreq starts the frame, and
// completion is found by following tx_idle low and then high again.  A byte
// presented with req_last=0 locks the arbiter to its owner so that a
// multi-byte packet stays contiguous on the line.
//
// Parameters:
//   N_REQ  number of requesters (2..8)
//   PTR_W  width of the round-robin pointer, 2**PTR_W >= N_REQ
//
// Ports:
//   clk_i        system clock, shared with uart_tx
//   reset_i      synchronous active-high reset
//   req_valid_i  requester i has a byte pending
//   req_data_i   byte of requester i at [8i+7:8i]
//   req_last_i   pending byte of requester i ends its packet
//   req_ready_o  one-hot, combinational: requester i's byte is taken this cycle
//   grant_o      one-hot owner of the current or locked frame, 0 when free
//   tx_wrreq_o   single-cycle write strobe to uart_tx
//   tx_wdata_o   byte to uart_tx, held for the whole frame
//   tx_idle_i    IDLE from uart_tx
//   busy_o       high outside ARB or while a packet lock is held
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic               tx_wrreq_o,
  output logic [7:0]         tx_wdata_o,
  input  logic               tx_idle_i,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    ST_ARB       = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  localparam logic [PTR_W:0]   N_EXT  = (PTR_W+1)'(N_REQ);
  localparam logic [N_REQ-1:0] OH_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic               lock_q, lock_d;
  logic [PTR_W-1:0]   lock_id_q, lock_id_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               wrreq_q, wrreq_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               busy_q, busy_d;

  logic               found_s;
  logic               hit_s;
  logic [PTR_W-1:0]   win_s;
  logic [PTR_W:0]     sum_s;
  logic [PTR_W:0]     cand_s;
  logic               accept_s;
  logic [N_REQ-1:0]   win_oh_s;
  logic               win_last_s;
  logic [7:0]         win_data_s;
  logic [PTR_W:0]     ptr_inc_s;
  logic [PTR_W-1:0]   next_ptr_s;

  // Winner search: first eligible valid requester scanning upward from rr_ptr.
  // While locked only the lock owner is eligible.
  always_comb begin
    found_s = 1'b0;
    hit_s   = 1'b0;
    win_s   = '0;
    sum_s   = '0;
    cand_s  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum_s   = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      cand_s  = (sum_s >= N_EXT) ? (sum_s - N_EXT) : sum_s;
      hit_s   = !found_s && req_valid_i[cand_s[PTR_W-1:0]] &&
                (!lock_q || (cand_s[PTR_W-1:0] == lock_id_q));
      win_s   = hit_s ? cand_s[PTR_W-1:0] : win_s;
      found_s = found_s | hit_s;
    end
  end

  // Acceptance decode; a frame is only started over an idle serializer.
  always_comb begin
    accept_s    = (state_q == ST_ARB) && tx_idle_i && found_s && !reset_i;
    win_oh_s    = OH_ONE << win_s;
    win_last_s  = req_last_i[win_s];
    win_data_s  = req_data_i[{win_s, 3'b000} +: 8];
    ptr_inc_s   = {1'b0, win_s} + (PTR_W+1)'(1);
    next_ptr_s  = (ptr_inc_s >= N_EXT) ? '0 : ptr_inc_s[PTR_W-1:0];
    req_ready_o = accept_s ? win_oh_s : '0;
  end

  // Next-state logic for the sequencer and its registered outputs.
  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    wdata_d   = wdata_q;
    case (state_q)
      ST_ARB: begin
        if (accept_s) begin
          state_d   = ST_ISSUE;
          wdata_d   = win_data_s;
          grant_d   = win_oh_s;
          lock_d    = !win_last_s;
          lock_id_d = win_s;
          // the pointer only moves at packet boundaries
          rr_ptr_d  = win_last_s ? next_ptr_s : rr_ptr_q;
        end else begin
          state_d = ST_ARB;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        state_d = tx_idle_i ? ST_WAIT_BUSY : ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tx_idle_i) begin
          state_d = ST_ARB;
          grant_d = lock_q ? grant_q : '0;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
    wrreq_d = (state_d == ST_ISSUE);
    busy_d  = (state_d != ST_ARB) || lock_d;
  end

  // Sequencer state and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_ARB;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      wrreq_q   <= 1'b0;
      wdata_q   <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      wrreq_q   <= wrreq_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
    end
  end

  assign grant_o    = grant_q;
  assign tx_wrreq_o = wrreq_q;
  assign tx_wdata_o = wdata_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int T = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]  req_last = '0;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  grant;
  logic          tx_wrreq;
  logic [7:0]    tx_wdata;
  logic          busy;

  // bench serializer state
  logic          u_idle = 1'b1;
  logic          u_line = 1'b1;
  int            u_bit = 0;
  int            u_tick = 0;
  logic [7:0]    u_shift = 8'h00;
  logic [7:0]    rx_q[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .PTR_W(2)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .grant_o     (grant),
    .tx_wrreq_o  (tx_wrreq),
    .tx_wdata_o  (tx_wdata),
    .tx_idle_i   (u_idle),
    .busy_o      (busy)
  );

  // Behavioural uart_tx: 10 bits of T clocks, reads wdata per bit, IDLE drops
  // on the edge that samples wrreq. The received byte is rebuilt from the line.
  always @(posedge clk) begin
    if (u_idle) begin
      if (tx_wrreq) begin
        u_idle <= 1'b0; u_bit <= 0; u_tick <= 0; u_line <= 1'b0;
      end
    end else begin
      if (u_tick == T/2 && u_bit >= 1 && u_bit <= 8) u_shift[u_bit-1] <= u_line;
      if (u_tick == T-1) begin
        u_tick <= 0;
        if (u_bit == 9) begin
          u_idle <= 1'b1;
          rx_q.push_back(u_shift);
        end else begin
          u_bit  <= u_bit + 1;
          u_line <= (u_bit < 8) ? tx_wdata[u_bit[2:0]] : 1'b1;
        end
      end else begin
        u_tick <= u_tick + 1;
      end
    end
  end

  int         vec = 0;
  int         miss = 0;
  logic [8:0] rq [N][$];     // {last, data} per requester
  int         exp_q[$];      // predicted acceptance order
  logic [7:0] sent_q[$];
  int         skip_idx = -1;
  int         m_ptr = 0;
  bit         m_lock = 1'b0;
  int         m_lid = 0;
  int         pop_id = -1;
  int         acc_id = 0;
  logic [7:0] acc_data = 8'h00;
  bit         wr_exp = 1'b0;
  bit         frame_active = 1'b0;
  bit         started = 1'b0;

  function automatic logic [3:0] onehot(input int w);
    logic [3:0] one;
    one = 4'b0001;
    return one << w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec++;
    assert (obs === expv) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input bit last);
    rq[r].push_back({last, d});
  endtask

  // Reference: replay the arbitration rules over the byte queues.
  function automatic void plan();
    int pos[N];
    int p, lid, w, c;
    bit lk, hit, last;
    p = m_ptr; lk = m_lock; lid = m_lid; w = 0;
    for (int i = 0; i < N; i++) pos[i] = 0;
    exp_q.delete();
    for (int g = 0; g < 1000; g++) begin
      hit = 1'b0;
      for (int k = 0; k < N; k++) begin
        c = (p + k) % N;
        if (!hit && pos[c] < rq[c].size() && (!lk || c == lid)) begin
          hit = 1'b1; w = c;
        end
      end
      if (!hit) break;
      exp_q.push_back(w);
      last = rq[w][pos[w]][8];
      pos[w]++;
      if (last) begin lk = 1'b0; p = (w + 1) % N; end
      else begin lk = 1'b1; lid = w; end
    end
    m_ptr = p; m_lock = lk; m_lid = lid;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = rq[i][0][7:0];
        req_last[i] = rq[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i] = 1'($urandom);
      end
    end
  endtask

  task automatic post_edge();
    if (pop_id >= 0) begin rq[pop_id].pop_front(); pop_id = -1; end
    check("wrreq", 32'(tx_wrreq), 32'(wr_exp));
    if (wr_exp) check("grant_issue", 32'(grant), 32'(onehot(acc_id)));
    if (frame_active) begin
      check("wdata_hold", 32'(tx_wdata), 32'(acc_data));
      check("busy_frame", 32'(busy), 32'd1);
      if (!u_idle) started = 1'b1;
      else if (started) begin frame_active = 1'b0; started = 1'b0; end
    end
  endtask

  task automatic sample_ready();
    check("ready_gated", 32'(req_ready != 4'b0000 && !u_idle), 32'd0);
    if (req_ready != 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("ready_unexpected", 32'(req_ready), 32'd0);
      end else begin
        acc_id = exp_q.pop_front();
        check("ready_winner", 32'(req_ready), 32'(onehot(acc_id)));
      end
      acc_data = (rq[acc_id].size() > 0) ? rq[acc_id][0][7:0] : 8'h00;
      sent_q.push_back(acc_data);
      pop_id = acc_id;
      frame_active = 1'b1;
      started = 1'b0;
      wr_exp = 1'b1;
    end else begin
      wr_exp = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    post_edge();
    drive();
    #1;
    sample_ready();
  endtask

  task automatic do_reset();
    @(negedge clk);
    if (pop_id >= 0) begin rq[pop_id].pop_front(); pop_id = -1; end
    reset = 1'b1;
    drive();
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("rst_wrreq", 32'(tx_wrreq), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wdata", 32'(tx_wdata), 32'd0);
    if (frame_active) skip_idx = sent_q.size() - 1;
    m_ptr = 0; m_lock = 1'b0; m_lid = 0;
    wr_exp = 1'b0; frame_active = 1'b0; started = 1'b0;
    plan();
    reset = 1'b0;
    drive();
    #1;
    sample_ready();
  endtask

  task automatic drain(input int extra);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || frame_active || pop_id >= 0) && n < 4000) begin
      cycle();
      n++;
    end
    check("drain_timeout", 32'(n >= 4000), 32'd0);
    for (int i = 0; i <= extra; i++) cycle();
    check("busy_rest", 32'(busy), 32'(m_lock));
    check("grant_rest", 32'(grant), m_lock ? 32'(onehot(m_lid)) : 32'd0);
  endtask

  initial begin
    int base, n, len;

    do_reset();

    // single requester, byte 0x41
    push(0, 8'h41, 1'b1);
    plan();
    drain(0);

    // all four from reset: A0..A3 in order, pointer wraps
    for (int i = 0; i < N; i++) push(i, 8'hA0 + 8'(i), 1'b1);
    do_reset();
    drain(0);

    // packet lock: move pointer to 2, then requester 2 packet vs requester 0
    push(1, 8'h55, 1'b1);
    plan();
    drain(0);
    push(2, 8'hB0, 1'b0); push(2, 8'hB1, 1'b0); push(2, 8'hB2, 1'b1);
    push(0, 8'hC0, 1'b1); push(0, 8'hC1, 1'b1);
    plan();
    drain(0);

    // fairness: requesters 1 and 3 alternate
    for (int j = 0; j < 3; j++) begin
      push(1, 8'h10 + 8'(j), 1'b1);
      push(3, 8'h30 + 8'(j), 1'b1);
    end
    do_reset();
    drain(0);

    // locked owner drops valid: others starve while the lock is held
    push(1, 8'h66, 1'b1);
    plan();
    drain(0);
    push(2, 8'hD0, 1'b0);
    push(0, 8'hE0, 1'b1);
    plan();
    drain(30);
    push(2, 8'hD1, 1'b1);
    plan();
    drain(0);

    // randomized packets
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) begin
        len = int'($urandom_range(0, 3));
        for (int j = 0; j < len; j++)
          push(i, 8'($urandom), (j == len - 1) ? 1'b1 : 1'($urandom_range(0, 1)));
      end
      plan();
      drain(0);
    end

    // reset while the serializer is mid-frame
    for (int i = 0; i < N; i++) begin
      push(i, 8'($urandom), 1'b1);
      push(i, 8'($urandom), 1'b1);
    end
    plan();
    base = sent_q.size();
    n = 0;
    while (!(sent_q.size() - base >= 2 && started) && n < 1000) begin
      cycle();
      n++;
    end
    check("midframe_timeout", 32'(n >= 1000), 32'd0);
    for (int i = 0; i < 5; i++) cycle();
    do_reset();
    drain(0);

    // serial line content against accepted bytes
    check("rx_count", 32'(rx_q.size()), 32'(sent_q.size()));
    for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++)
      if (i != skip_idx) check("rx_byte", 32'(rx_q[i]), 32'(sent_q[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
